// File: rtl/audio_sample_pacer.sv
// Stereo sample FIFO and sample-rate pacer feeding the PWM/sigma-delta DAC with offset-binary pairs.
// Optional build macro AUDIO_PACER_RAMP_EN: ramp outputs toward midscale on underrun instead of holding.
module audio_sample_pacer #(
  parameter int depthbits = 4,
  parameter int divbits   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [15:0]   s_l,
  input  logic signed [15:0]   s_r,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [divbits-1:0]   period,
  input  logic                 flush,
  input  logic                 underrun_clr,
  output logic [15:0]          d_l,
  output logic [15:0]          d_r,
  output logic                 tick,
  output logic                 underrun,
  output logic [depthbits:0]   level
);

  localparam int                 DATA_W  = 16;
  localparam int                 DEPTH   = 1 << depthbits;
  localparam logic [DATA_W-1:0]  MID     = 16'h8000;
  localparam logic [divbits-1:0] MIN_P   = divbits'(3);
  localparam logic [divbits-1:0] DIV_ONE = divbits'(1);
  localparam logic [depthbits:0] PTR_ONE = (depthbits + 1)'(1);

  function automatic logic [DATA_W-1:0] to_offset(input logic signed [DATA_W-1:0] s);
    return {~s[DATA_W-1], s[DATA_W-2:0]};
  endfunction

`ifdef AUDIO_PACER_RAMP_EN
  localparam logic [DATA_W-1:0] STEP = 16'h0100;

  // Moves one step toward midscale, snapping onto it when within one step.
  function automatic logic [DATA_W-1:0] ramp_mid(input logic [DATA_W-1:0] d);
    if (d > MID + STEP)      return d - STEP;
    else if (d < MID - STEP) return d + STEP;
    else                     return MID;
  endfunction
`endif

  logic [depthbits:0]    wptr, rptr;
  logic [2*DATA_W-1:0]   mem [DEPTH];
  logic [2*DATA_W-1:0]   head;
  logic                  full, empty;
  logic                  wr_en, pop, und_set;
  logic [divbits-1:0]    cnt, period_eff;
  logic                  load_pend;

  assign full       = (wptr[depthbits] != rptr[depthbits]) &&
                      (wptr[depthbits-1:0] == rptr[depthbits-1:0]);
  assign empty      = (wptr == rptr);
  assign s_ready    = !full;
  assign level      = wptr - rptr;
  assign head       = mem[rptr[depthbits-1:0]];
  assign period_eff = (period < MIN_P) ? MIN_P : period;

  // Tick is sampled registered, so a pair accepted on the tick cycle waits for the next period.
  assign wr_en   = s_valid && !full && !flush;
  assign pop     = tick && !empty && !flush;
  assign und_set = tick && empty;

  // Divider: the first load after reset already spends one clock, hence the minus one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      load_pend <= 1'b1;
      tick      <= 1'b0;
    end else if (load_pend) begin
      cnt       <= period_eff - DIV_ONE;
      load_pend <= 1'b0;
      tick      <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= period_eff;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - DIV_ONE;
      tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[depthbits-1:0]] <= {s_l, s_r};
  end

  // Output stage: changes only on the clock following a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_l <= MID;
      d_r <= MID;
    end else if (pop) begin
      d_l <= to_offset(head[2*DATA_W-1:DATA_W]);
      d_r <= to_offset(head[DATA_W-1:0]);
    end else if (und_set) begin
`ifdef AUDIO_PACER_RAMP_EN
      d_l <= ramp_mid(d_l);
      d_r <= ramp_mid(d_r);
`else
      d_l <= d_l;
      d_r <= d_r;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          underrun <= 1'b0;
    else if (und_set)      underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

endmodule
